// File: rtl/vpe_pkg.sv
// Shared fp16 types, tile latency and accumulator state for the vector tile.
package vpe_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO     = 16'h0000;
  localparam int    TILE_SCAL_LAT = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    ACC   = 1'b1
  } acc_state_e;

  function automatic logic fp16_is_nan(input fp16_t v);
    return (&v[14:10]) && (|v[9:0]);
  endfunction

endpackage

// File: rtl/accum_out_fifo.sv
// Synchronous FIFO of {fp16 result, chunk count}; occupancy is exported for issue credit.
module accum_out_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // a full FIFO still takes a push when the head leaves in the same cycle
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/new_fp16_add.sv
// Combinational fp16 adder, round-to-nearest-even, subnormal aware, NaN/Inf propagating.
module new_fp16_add
  import vpe_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  output fp16_t sum_o
);

  fp16_t       big, sml;
  logic [4:0]  eb, es, sh;
  logic [13:0] mb, ms, nrm;
  logic [14:0] raw;
  logic [5:0]  exp_n;
  logic [11:0] rnd;
  logic        sub, round_up, a_inf, b_inf;

  always_comb begin
    a_inf = (&a_i[14:10]) && !(|a_i[9:0]);
    b_inf = (&b_i[14:10]) && !(|b_i[9:0]);
    if (a_i[14:0] >= b_i[14:0]) begin
      big = a_i;
      sml = b_i;
    end else begin
      big = b_i;
      sml = a_i;
    end
    eb = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    es = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    // {hidden, fraction, guard, round, sticky}
    mb = {|big[14:10], big[9:0], 3'b000};
    ms = {|sml[14:10], sml[9:0], 3'b000};
    sh = eb - es;
    for (int i = 0; i < 14; i++) begin
      if (5'(i) < sh) ms = {1'b0, ms[13:2], ms[1] | ms[0]};
    end
    sub = big[15] ^ sml[15];
    raw = sub ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
    exp_n = {1'b0, eb};
    if (raw[14]) begin
      nrm   = {raw[14:2], raw[1] | raw[0]};
      exp_n = exp_n + 6'd1;
    end else begin
      nrm = raw[13:0];
      for (int i = 0; i < 13; i++) begin
        if (!nrm[13] && exp_n > 6'd1) begin
          nrm   = nrm << 1;
          exp_n = exp_n - 6'd1;
        end
      end
    end
    round_up = nrm[2] && (nrm[1] || nrm[0] || nrm[3]);
    rnd = {1'b0, nrm[13:3]} + 12'(round_up);
    if (rnd[11]) begin
      rnd   = rnd >> 1;
      exp_n = exp_n + 6'd1;
    end
    if (fp16_is_nan(a_i))      sum_o = a_i;
    else if (fp16_is_nan(b_i)) sum_o = b_i;
    else if (a_inf && b_inf && (a_i[15] != b_i[15])) sum_o = 16'h7E00;
    else if (a_inf)            sum_o = a_i;
    else if (b_inf)            sum_o = b_i;
    else if (raw == 15'd0)     sum_o = {big[15] & sml[15], 15'h0000};
    else if (exp_n >= 6'd31)   sum_o = {big[15], 5'h1F, 10'h000};
    else                       sum_o = {big[15], rnd[10] ? exp_n[4:0] : 5'd0, rnd[9:0]};
  end

endmodule

// File: rtl/reconf_accum.sv
// Chunk accumulator behind the multiply/adder tile; RECONF_ACCUM_RELU_EN adds ReLU on results.
// state | meaning
// EMPTY | no chunk of the current product summed yet
// ACC   | one or more chunks summed, no last seen
module reconf_accum
  import vpe_pkg::*;
#(
  parameter int SCAL_LAT   = TILE_SCAL_LAT,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [15:0]      scal_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int FW = 16 + CNT_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH + SCAL_LAT + 1) + 1;

  acc_state_e          state_q, state_d;
  fp16_t               acc_q, acc_d, add_y, sum, res;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_new;
  logic [SCAL_LAT-1:0] dv_q, dv_d, dl_q, dl_d;
  logic [PW-1:0]       pending;
  logic [CW-1:0]       fifo_cnt;
  logic [FW-1:0]       head;
  logic                accept, pop, push, dv, dl;

  new_fp16_add u_add (
    .a_i  (acc_q),
    .b_i  (scal_i),
    .sum_o(add_y)
  );

  always_comb begin
    // every last already in flight owns a FIFO slot
    pending = PW'(fifo_cnt);
    for (int i = 0; i < SCAL_LAT; i++) pending = pending + PW'(dv_q[i] & dl_q[i]);
    pop      = out_valid && out_ready;
    in_ready = !in_last || ((pending - PW'(pop)) < PW'(FIFO_DEPTH));
    accept   = in_valid && in_ready;

    dv_d    = '0;
    dl_d    = '0;
    dv_d[0] = accept;
    dl_d[0] = accept && in_last;
    for (int i = 1; i < SCAL_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      dl_d[i] = dl_q[i-1];
    end
    dv = dv_q[SCAL_LAT-1];
    dl = dl_q[SCAL_LAT-1];

    sum     = (state_q == EMPTY) ? fp16_t'(scal_i) : add_y;
    cnt_new = (state_q == EMPTY) ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    res     = sum;
`ifdef RECONF_ACCUM_RELU_EN
    if (sum[15] && !fp16_is_nan(sum)) res = FP16_ZERO;
`endif
    push = dv && dl;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (dv) begin
      if (dl) begin
        state_d = EMPTY;
        acc_d   = FP16_ZERO;
        cnt_d   = '0;
      end else begin
        state_d = ACC;
        acc_d   = sum;
        cnt_d   = cnt_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      acc_q   <= FP16_ZERO;
      cnt_q   <= '0;
      dv_q    <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      dl_q    <= dl_d;
    end
  end

  accum_out_fifo #(
    .DEPTH(FIFO_DEPTH),
    .DW   (FW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({res, cnt_new}),
    .pop      (pop),
    .head     (head),
    .valid    (out_valid),
    .count    (fifo_cnt)
  );

  assign out_data  = head[FW-1:CNT_W];
  assign out_count = head[CNT_W-1:0];
  assign busy      = (|dv_q) || (state_q == ACC);

endmodule

// File: tb/tb_reconf_accum.sv
// Scoreboard bench for reconf_accum: directed chunk sequences, queued expectations, output monitor.
module tb_reconf_accum;

  localparam int SCAL_LAT = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } exp_t;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_last, in_ready;
  logic [15:0] chunk_val, p1, p2;
  logic        out_valid, out_ready, busy;
  logic [15:0] out_data;
  logic [7:0]  out_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // tile model: o_scal appears SCAL_LAT cycles after the operands
  always @(posedge clk) begin
    p1 <= chunk_val;
    p2 <= p1;
  end

  reconf_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .scal_i   (p2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [7:0] c);
    exp_q.push_back({d, c});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic last, input logic [15:0] v);
    int n = 0;
    in_valid  = 1;
    in_last   = last;
    chunk_val = v;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("issue_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 0;
    in_last   = 0;
    chunk_val = 16'h0000;
  endtask

  // entered one cycle after the last chunk was accepted
  task automatic expect_latency(input string name);
    for (int i = 1; i <= SCAL_LAT + 1; i++) begin
      chk(name, 32'(out_valid), 32'(i == SCAL_LAT + 1));
      if (i <= SCAL_LAT) idle(1);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  initial begin : monitor
    exp_t        e;
    logic        hv;
    logic [15:0] hd;
    logic [7:0]  hc;
    hv = 0;
    hd = '0;
    hc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 0;
      end else begin
        if (hv) begin
          checks++;
          if (!out_valid || out_data !== hd || out_count !== hc) begin
            errors++;
            $display("FAIL hold actual=%0b/%h/%0d required=1/%h/%0d",
                     out_valid, out_data, out_count, hd, hc);
          end
        end
        hv = out_valid && !out_ready;
        hd = out_data;
        hc = out_count;
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out actual=%h/%0d required=none", out_data, out_count);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_count !== e.c) begin
              errors++;
              $display("FAIL result actual=%h/%0d required=%h/%0d", out_data, out_count, e.d, e.c);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n     = 0;
    in_valid  = 0;
    in_last   = 0;
    out_ready = 1;
    chunk_val = 16'h0000;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // single chunk
    push_exp(16'h3C00, 8'd1);
    issue(1, 16'h3C00);
    chk("single_busy_on", 32'(busy), 32'd1);
    expect_latency("single_latency");
    chk("single_busy_off", 32'(busy), 32'd0);
    wait_drain("single_drain");

    // three chunks with a bubble: 1 + 2 + 3 = 6
    push_exp(16'h4600, 8'd3);
    issue(0, 16'h3C00);
    issue(0, 16'h4000);
    idle(1);
    issue(1, 16'h4200);
    expect_latency("three_latency");
    wait_drain("three_drain");

    // backpressure: four lasts fill the credit, the fifth waits for a pop
    out_ready = 0;
    push_exp(16'h3C00, 8'd1);
    issue(1, 16'h3C00);
    push_exp(16'h4000, 8'd1);
    issue(1, 16'h4000);
    push_exp(16'h4200, 8'd1);
    issue(1, 16'h4200);
    push_exp(16'h4400, 8'd1);
    issue(1, 16'h4400);
    push_exp(16'h4500, 8'd1);
    in_valid  = 1;
    in_last   = 1;
    chunk_val = 16'h4500;
    #1;
    chk("bp_blocked", 32'(in_ready), 32'd0);
    in_last = 0;
    #1;
    chk("bp_nonlast_ready", 32'(in_ready), 32'd1);
    in_last = 1;
    #1;
    repeat (4) begin
      @(posedge clk);
      #2;
      chk("bp_blocked_hold", 32'(in_ready), 32'd0);
    end
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    #1;
    chk("bp_ready_on_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 0;
    in_last   = 0;
    chunk_val = 16'h0000;
    wait_drain("bp_drain");

    // full FIFO, results keep flowing while pushes coincide with pops
    out_ready = 0;
    push_exp(16'h4800, 8'd1);
    issue(1, 16'h4800);
    push_exp(16'h4900, 8'd1);
    issue(1, 16'h4900);
    push_exp(16'h4A00, 8'd1);
    issue(1, 16'h4A00);
    push_exp(16'h4B00, 8'd1);
    issue(1, 16'h4B00);
    idle(2);
    out_ready = 1;
    push_exp(16'h4C00, 8'd1);
    issue(1, 16'h4C00);
    push_exp(16'h4D00, 8'd1);
    issue(1, 16'h4D00);
    wait_drain("pushpop_drain");

    // reset in the middle of a product discards it
    issue(0, 16'h4400);
    issue(0, 16'h4400);
    rst_n = 0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    idle(1);
    rst_n = 1;
    push_exp(16'h4000, 8'd1);
    issue(1, 16'h4000);
    wait_drain("midrst_drain");

    // negative sum, then NaN propagation
`ifdef RECONF_ACCUM_RELU_EN
    push_exp(16'h0000, 8'd2);
`else
    push_exp(16'hBC00, 8'd2);
`endif
    issue(0, 16'h3C00);
    issue(1, 16'hC000);
    push_exp(16'hFE00, 8'd2);
    issue(0, 16'h3C00);
    issue(1, 16'hFE00);
    wait_drain("relu_drain");

    // chunk count saturates at all-ones
    push_exp(16'h0000, 8'hFF);
    for (int i = 0; i < 300; i++) issue(0, 16'h0000);
    issue(1, 16'h0000);
    wait_drain("sat_drain");

    idle(5);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
